// File: rtl/cnn_argmax_classifier.sv
// Sequential argmax over the dense-layer class scores: captures ten signed
// logits on start, scans one per cycle, then publishes winner, score and margin.
module cnn_argmax_classifier #(
  parameter int unsigned LOGIT_BIT   = 35,
  parameter int unsigned CLASS_COUNT = 10,
  parameter int unsigned CLASS_BIT   = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic [CLASS_COUNT*LOGIT_BIT-1:0] logits_in,
  output logic                             busy,
  output logic                             valid,
  output logic [CLASS_BIT-1:0]             class_out,
  output logic [LOGIT_BIT-1:0]             max_logit,
  output logic [LOGIT_BIT-1:0]             margin
);

  typedef enum logic [1:0] {IDLE, SCAN, OUT} state_t;

  localparam logic [CLASS_BIT-1:0]        LAST_IDX = CLASS_BIT'(CLASS_COUNT - 1);
  localparam logic signed [LOGIT_BIT-1:0] MOST_NEG = {1'b1, {(LOGIT_BIT-1){1'b0}}};

  state_t                       state, state_next;
  logic signed [LOGIT_BIT-1:0]  score_q [CLASS_COUNT];
  logic [CLASS_BIT-1:0]         idx;
  logic [CLASS_BIT-1:0]         best_idx;
  logic signed [LOGIT_BIT-1:0]  best;
  logic signed [LOGIT_BIT-1:0]  second;
  logic signed [LOGIT_BIT-1:0]  x;
  logic [LOGIT_BIT:0]           diff;

  assign x    = score_q[idx];
  assign busy = (state != IDLE);
  // One extra bit so best - second (at most 2^LOGIT_BIT - 1) never wraps.
  assign diff = {best[LOGIT_BIT-1], best} - {second[LOGIT_BIT-1], second};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SCAN;
      SCAN:    if (idx == LAST_IDX) state_next = OUT;
      OUT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < CLASS_COUNT; i++) score_q[i] <= '0;
      idx       <= '0;
      best_idx  <= '0;
      best      <= '0;
      second    <= '0;
      valid     <= 1'b0;
      class_out <= '0;
      max_logit <= '0;
      margin    <= '0;
    end else begin
      valid <= (state == OUT);
      case (state)
        IDLE: begin
          if (start) begin
            for (int unsigned i = 0; i < CLASS_COUNT; i++)
              score_q[i] <= logits_in[i*LOGIT_BIT +: LOGIT_BIT];
            idx <= '0;
          end
        end
        SCAN: begin
          // Strict compares keep the lowest index on ties; the tied score drops to second.
          if (idx == '0) begin
            best     <= x;
            best_idx <= '0;
            second   <= MOST_NEG;
          end else if (x > best) begin
            second   <= best;
            best     <= x;
            best_idx <= idx;
          end else if (x > second) begin
            second   <= x;
          end
          if (idx != LAST_IDX) idx <= idx + 1'b1;
        end
        OUT: begin
          class_out <= best_idx;
          max_logit <= best;
          margin    <= diff[LOGIT_BIT-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule
